// File: rtl/fetch_stage_if.sv
// Instruction-memory fetch bus between the fetch stage and instruction memory.
// Latency: none; this is wiring only.
// Backpressure: the master holds imem_req and imem_addr stable until the slave returns imem_ack.
//
// Signals:
//   imem_req   master->slave  fetch request
//   imem_addr  master->slave  word address of the outstanding fetch
//   imem_ack   slave->master  response valid; may come in the same cycle as imem_req
//   imem_rdata slave->master  instruction word, valid with imem_ack
interface fetch_stage_if #(
  parameter int AW = 32
);
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [31:0]   imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage with IF/ID register, one-entry skid buffer and redirect handling.
// Latency: one cycle from imem_ack to valid_d; back-to-back fetches with a same-cycle ack.
// Backpressure: stall parks one returned word in the skid buffer and stops requesting.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   imem                   fetch bus (master): imem_req/imem_addr out, imem_ack/imem_rdata in
//   stall                  hazard unit holds the IF/ID register
//   redirect, redirect_pc  taken branch/jump from execute; low two target bits are ignored
//   valid_d, instr_d       IF/ID register contents
//   opcode_d               instr_d[31:26], for the main decoder
//   pc_plus4_d             PC+4 of instr_d
//   fetch_cnt, bubble_cnt  performance counters, present only with FETCH_PERF_CNT_EN defined
//
// RESET_PC must be word aligned; the PC only ever moves in word steps from there.
module fetch_stage #(
  parameter int            AW       = 32,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.master imem,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          valid_d,
  output logic [31:0]   instr_d,
  output logic [5:0]    opcode_d,
  output logic [AW-1:0] pc_plus4_d
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]   fetch_cnt,
  output logic [31:0]   bubble_cnt
`endif
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    SQUASH = 2'd3
  } state_t;

  state_t        state_q, state_n;
  logic [AW-1:0] pc_q, pc_n;
  logic [AW-1:0] sq_addr_q, sq_addr_n;   // address of the request being squashed
  logic [AW-1:0] pc_plus4_q, pc_plus4_n;
  logic [31:0]   instr_q, instr_n;
  logic [31:0]   skid_q, skid_n;
  logic          valid_q, valid_n;
  logic          load_live;              // IF/ID loaded with a live instruction this cycle

  logic [AW-1:0] pc_inc;
  logic [AW-1:0] target;
  logic          unused_redirect_lsb;

  assign pc_inc              = pc_q + AW'(4);
  assign target              = {redirect_pc[AW-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      sq_addr_q  <= '0;
      pc_plus4_q <= '0;
      instr_q    <= '0;
      skid_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_n;
      pc_q       <= pc_n;
      sq_addr_q  <= sq_addr_n;
      pc_plus4_q <= pc_plus4_n;
      instr_q    <= instr_n;
      skid_q     <= skid_n;
      valid_q    <= valid_n;
    end
  end

  always_comb begin
    state_n    = state_q;
    pc_n       = pc_q;
    sq_addr_n  = sq_addr_q;
    pc_plus4_n = pc_plus4_q;
    instr_n    = instr_q;
    skid_n     = skid_q;
    valid_n    = valid_q;
    load_live  = 1'b0;

    case (state_q)
      BOOT: begin
        if (redirect) begin
          pc_n    = target;
          valid_n = 1'b0;
        end
        state_n = FETCH;
      end

      FETCH: begin
        if (redirect) begin
          valid_n = 1'b0;
          pc_n    = target;
          // The request is on the bus and cannot be withdrawn: remember its
          // address and wait for its response so it can be thrown away.
          if (!imem.imem_ack) begin
            sq_addr_n = pc_q;
            state_n   = SQUASH;
          end
        end else if (imem.imem_ack) begin
          pc_n = pc_inc;
          if (!stall) begin
            instr_n    = imem.imem_rdata;
            pc_plus4_n = pc_inc;
            valid_n    = 1'b1;
            load_live  = 1'b1;
          end else begin
            skid_n  = imem.imem_rdata;
            state_n = HOLD;
          end
        end else if (!stall) begin
          valid_n = 1'b0;
        end
      end

      HOLD: begin
        // No request is outstanding here, so a redirect can fetch the target at once.
        if (redirect) begin
          valid_n = 1'b0;
          pc_n    = target;
          state_n = FETCH;
        end else if (!stall) begin
          // pc already points past the skid word, so it is that word's PC+4.
          instr_n    = skid_q;
          pc_plus4_n = pc_q;
          valid_n    = 1'b1;
          load_live  = 1'b1;
          state_n    = FETCH;
        end
      end

      SQUASH: begin
        if (redirect) begin
          valid_n = 1'b0;
          pc_n    = target;
        end
        if (imem.imem_ack) begin
          state_n = FETCH;
        end
      end

      default: state_n = BOOT;
    endcase
  end

  assign imem.imem_req  = (state_q == FETCH) || (state_q == SQUASH);
  assign imem.imem_addr = (state_q == SQUASH) ? sq_addr_q : pc_q;

  assign valid_d    = valid_q;
  assign instr_d    = instr_q;
  assign opcode_d   = instr_q[31:26];
  assign pc_plus4_d = pc_plus4_q;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      if (load_live) begin
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      end
      if ((state_q != BOOT) && !valid_q) begin
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
      end
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`else
  logic unused_load_live;
  assign unused_load_live = load_live;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: linear stimulus, hand-computed expectations.
// Instruction memory model returns imem_rdata = imem_addr after mem_lat request cycles.
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [5:0]  opcode_d;
  logic [31:0] pc_plus4_d;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  int n_checks;
  int n_fail;
  int mem_lat;
  int mem_cnt;

  fetch_stage_if #(.AW(32)) imem_bus ();

  fetch_stage #(.AW(32), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem        (imem_bus),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .valid_d     (valid_d),
    .instr_d     (instr_d),
    .opcode_d    (opcode_d),
    .pc_plus4_d  (pc_plus4_d)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .bubble_cnt  (bubble_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: decides the ack for the current cycle shortly after the rising edge.
  initial begin
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    mem_cnt             = 0;
    forever begin
      @(posedge clk);
      #2;
      if (imem_bus.imem_req) begin
        if (mem_cnt + 1 >= mem_lat) begin
          imem_bus.imem_ack   = 1'b1;
          imem_bus.imem_rdata = imem_bus.imem_addr;
          mem_cnt             = 0;
        end else begin
          imem_bus.imem_ack   = 1'b0;
          imem_bus.imem_rdata = 32'hDEAD_BEEF;
          mem_cnt             = mem_cnt + 1;
        end
      end else begin
        imem_bus.imem_ack   = 1'b0;
        imem_bus.imem_rdata = 32'hDEAD_BEEF;
        mem_cnt             = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    mem_lat     = 1;
    rst_n       = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;

    // Reset state
    step(); step();
    chk("rst_req",   {31'b0, imem_bus.imem_req}, 32'd0);
    chk("rst_valid", {31'b0, valid_d}, 32'd0);
    chk("rst_instr", instr_d, 32'd0);
    chk("rst_pp4",   pc_plus4_d, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fcnt", fetch_cnt, 32'd0);
    chk("rst_bcnt", bubble_cnt, 32'd0);
`endif

    // Single-cycle memory, no stall
    rst_n = 1'b1;
    #1;
    chk("boot_req", {31'b0, imem_bus.imem_req}, 32'd0);
    step();
    chk("f1_req",   {31'b0, imem_bus.imem_req}, 32'd1);
    chk("f1_addr",  imem_bus.imem_addr, 32'h0);
    chk("f1_valid", {31'b0, valid_d}, 32'd0);
    step();
    chk("f2_addr",  imem_bus.imem_addr, 32'h4);
    chk("f2_valid", {31'b0, valid_d}, 32'd1);
    chk("f2_pp4",   pc_plus4_d, 32'h4);
    chk("f2_instr", instr_d, 32'h0);
    step();
    chk("f3_addr",  imem_bus.imem_addr, 32'h8);
    chk("f3_pp4",   pc_plus4_d, 32'h8);
    chk("f3_instr", instr_d, 32'h4);
    step();
    chk("f4_addr",  imem_bus.imem_addr, 32'hC);
    chk("f4_pp4",   pc_plus4_d, 32'hC);
    chk("f4_instr", instr_d, 32'h8);
    mem_lat = 3;

    // Three-cycle memory latency
    step();
    chk("l3_addr0",  imem_bus.imem_addr, 32'h10);
    chk("l3_valid0", {31'b0, valid_d}, 32'd1);
    chk("l3_instr0", instr_d, 32'hC);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("l3_hold_addr", imem_bus.imem_addr, 32'h10);
      chk("l3_bubble",    {31'b0, valid_d}, 32'd0);
    end
    step();
    chk("l3_addr1",  imem_bus.imem_addr, 32'h14);
    chk("l3_valid1", {31'b0, valid_d}, 32'd1);
    chk("l3_instr1", instr_d, 32'h10);
    chk("l3_pp4_1",  pc_plus4_d, 32'h14);
    for (int k = 0; k < 2; k++) begin
      step();
      chk("l3_bubble2", {31'b0, valid_d}, 32'd0);
    end
    step();
    chk("l3_valid2", {31'b0, valid_d}, 32'd1);
    chk("l3_instr2", instr_d, 32'h14);

    // Fresh reset, then stall coinciding with the ack of 0x8
    rst_n   = 1'b0;
    mem_lat = 1;
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("st_pre_instr", instr_d, 32'h0);
    step();
    chk("st_addr8",  imem_bus.imem_addr, 32'h8);
    chk("st_instr4", instr_d, 32'h4);
    stall = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("st_req_low",  {31'b0, imem_bus.imem_req}, 32'd0);
      chk("st_hold_ifid", instr_d, 32'h4);
      chk("st_hold_vld", {31'b0, valid_d}, 32'd1);
    end
    stall = 1'b0;
    step();
    chk("st_rel_instr", instr_d, 32'h8);
    chk("st_rel_pp4",   pc_plus4_d, 32'hC);
    chk("st_rel_valid", {31'b0, valid_d}, 32'd1);
    chk("st_rel_addr",  imem_bus.imem_addr, 32'hC);
    mem_lat = 3;
    step();
    chk("st_next_instr", instr_d, 32'hC);
    chk("st_next_pp4",   pc_plus4_d, 32'h10);
    chk("st_next_addr",  imem_bus.imem_addr, 32'h10);

    // Redirect while the fetch of 0x10 is outstanding
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    step();
    redirect = 1'b0;
    chk("sq_req",   {31'b0, imem_bus.imem_req}, 32'd1);
    chk("sq_addr",  imem_bus.imem_addr, 32'h10);
    chk("sq_valid", {31'b0, valid_d}, 32'd0);
    step();
    chk("sq_addr2",  imem_bus.imem_addr, 32'h10);
    chk("sq_valid2", {31'b0, valid_d}, 32'd0);
    mem_lat = 1;
    step();
    chk("sq_tgt_addr", imem_bus.imem_addr, 32'h40);
    chk("sq_dropped",  {31'b0, valid_d}, 32'd0);
    chk("sq_instr",    instr_d, 32'hC);
    step();
    chk("tgt_instr", instr_d, 32'h40);
    chk("tgt_valid", {31'b0, valid_d}, 32'd1);
    chk("tgt_pp4",   pc_plus4_d, 32'h44);
    chk("tgt_addr",  imem_bus.imem_addr, 32'h44);

    // Redirect to an unaligned target together with ack and stall
    redirect    = 1'b1;
    redirect_pc = 32'h83;
    stall       = 1'b1;
    step();
    redirect = 1'b0;
    stall    = 1'b0;
    chk("ra_addr",  imem_bus.imem_addr, 32'h80);
    chk("ra_req",   {31'b0, imem_bus.imem_req}, 32'd1);
    chk("ra_valid", {31'b0, valid_d}, 32'd0);
    chk("ra_instr", instr_d, 32'h40);
    step();
    chk("ra_new_instr", instr_d, 32'h80);
    chk("ra_new_pp4",   pc_plus4_d, 32'h84);

    // PC wrap at the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect = 1'b0;
    chk("wr_addr",  imem_bus.imem_addr, 32'hFFFF_FFFC);
    chk("wr_valid", {31'b0, valid_d}, 32'd0);
    step();
    chk("wr_instr",  instr_d, 32'hFFFF_FFFC);
    chk("wr_pp4",    pc_plus4_d, 32'h0);
    chk("wr_addr0",  imem_bus.imem_addr, 32'h0);
    chk("wr_opcode", {26'b0, opcode_d}, 32'h3F);
    mem_lat = 3;
    step();
    chk("pre_sq_addr",  imem_bus.imem_addr, 32'h4);
    chk("pre_sq_instr", instr_d, 32'h0);

    // Reset in the middle of SQUASH
    redirect    = 1'b1;
    redirect_pc = 32'h100;
    step();
    redirect = 1'b0;
    chk("ms_addr", imem_bus.imem_addr, 32'h4);
    chk("ms_req",  {31'b0, imem_bus.imem_req}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("ar_req",   {31'b0, imem_bus.imem_req}, 32'd0);
    chk("ar_valid", {31'b0, valid_d}, 32'd0);
    chk("ar_instr", instr_d, 32'd0);
    chk("ar_pp4",   pc_plus4_d, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("ar_fcnt", fetch_cnt, 32'd0);
    chk("ar_bcnt", bubble_cnt, 32'd0);
`endif
    step();
    rst_n   = 1'b1;
    mem_lat = 1;
    step();
    chk("rr_req",  {31'b0, imem_bus.imem_req}, 32'd1);
    chk("rr_addr", imem_bus.imem_addr, 32'h0);
    step();
    chk("rr_instr", instr_d, 32'h0);
    chk("rr_valid", {31'b0, valid_d}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the main decoder.
- Holds the PC and issues word fetches to instruction memory over a req/ack handshake.
- Latches returned instructions into the IF/ID register; opcode_d drives the main decoder's opcode input.
- Absorbs downstream stalls with a one-entry skid buffer and applies branch/jump redirects from the execute stage.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- AW, 32, PC/address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held with stable imem_addr until imem_ack.
- imem_addr  out  AW  word address of the outstanding fetch (bits[1:0] always 0).
- imem_ack  in  1  response valid; may arrive in the same cycle as imem_req or any later cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- stall  in  1  hazard unit holds the IF/ID register.
- redirect  in  1  taken branch/jump: flush and refetch.
- redirect_pc  in  AW  target address; bits[1:0] are ignored and forced to 0.
- valid_d  out  1  IF/ID contents are a live instruction.
- instr_d  out  32  IF/ID instruction.
- opcode_d  out  6  instr_d[31:26], wired to the main decoder.
- pc_plus4_d  out  AW  PC+4 of instr_d, used for branch target and JAL link value.

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, state=BOOT, imem_req=0, valid_d=0, instr_d=0, pc_plus4_d=0, skid empty.
- First imem_req is asserted in the first clock after rst_n deasserts.
- A reset asserted mid-transaction abandons it immediately; the memory must tolerate the dropped req.
- States:
  - BOOT -> FETCH unconditionally.
  - FETCH: imem_req=1, imem_addr=pc.
  - HOLD: imem_req=0; skid buffer full.
  - SQUASH: imem_req=1 with the old address; waiting to discard a stale response.
- FETCH, ack and !stall:
  - instr_d<=imem_rdata, pc_plus4_d<=pc+4, valid_d<=1, pc<=pc+4.
  - Stay in FETCH; next request is back-to-back with the new address.
- FETCH, ack and stall: skid<=imem_rdata, pc<=pc+4, go to HOLD. IF/ID is unchanged.
- FETCH, no ack and !stall: valid_d<=0 (bubble).
- FETCH, no ack and stall: IF/ID is unchanged.
- HOLD, !stall: IF/ID<=skid with pc_plus4_d=pc, valid_d<=1, go to FETCH.
- HOLD, stall: hold all state.
- Redirect has top priority in every state, regardless of stall:
  - valid_d<=0, skid emptied, pc<={redirect_pc[AW-1:2],2'b00}.
  - FETCH with no ack this cycle -> SQUASH.
  - FETCH with ack this cycle -> data discarded; FETCH on the target next cycle.
  - HOLD or SQUASH -> SQUASH only if a request is still outstanding, else FETCH.
- SQUASH: on ack, discard imem_rdata and go to FETCH at pc (target). A second redirect while in SQUASH only updates pc.
- Requests are never withdrawn once issued: imem_req and imem_addr stay stable until ack, except on reset.
- PC arithmetic is modulo 2^AW; PC+4 at the top of the address space wraps to 0.
- A stall held for N cycles produces no fetch after the skid fills; an instruction is never lost or duplicated.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_cnt (32) and bubble_cnt (32), both reset to 0, wrapping at 2^32.
  - fetch_cnt increments on each cycle valid_d is loaded with 1.
  - bubble_cnt increments on each cycle valid_d=0 after BOOT.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, 1-cycle ack memory returning imem_rdata=addr, no stall -> imem_addr 0,4,8,...; valid_d=1 from the 2nd fetch cycle; pc_plus4_d=4,8,12.
- 3-cycle ack latency -> imem_addr held stable for 3 cycles; valid_d pulses 1 every 3rd cycle with bubbles between.
- stall=1 for 4 cycles coinciding with ack of 0x8 -> IF/ID holds 0x4; imem_req low 3 cycles; after release instr_d=0x8, then 0xC with no gap or repeat.
- redirect with redirect_pc=0x40 while fetch of 0x10 is outstanding (ack 2 cycles later) -> valid_d=0; imem_addr stays 0x10 until ack; data dropped; next imem_addr=0x40.
- redirect with redirect_pc=0x83 in the same cycle as ack and stall=1 -> data discarded; next imem_addr=0x80; valid_d=0.
- rst_n pulsed low mid-SQUASH -> all outputs return to reset values asynchronously; first fetch after release is RESET_PC. With FETCH_PERF_CNT_EN defined, both counters read 0.
